// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
//
// It handles MULT, MULTU, DIV and DIVU over WIDTH cycles: one shift-add or
// restoring shift-subtract step per cycle, done on operand magnitudes. A
// single FIX cycle then applies sign correction.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   start        operation request; ignored while busy
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we MTHI/MTLO write enables; only honoured in IDLE when start is low
//   wdata        MTHI/MTLO write data
//   busy         high in RUN, FIX and DONE
//   done         one-cycle completion pulse (DONE state)
//   hi, lo       architectural HI/LO registers
//   div_by_zero  set by a DIV/DIVU with b == 0, cleared by any other completion
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;     // |a| for multiply, |b| (divisor) for divide
    logic [2*WIDTH-1:0] prod_q, prod_d;       // {accumulator/remainder, multiplier/quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    // Operand magnitudes at capture time
    logic               in_signed;
    logic               in_a_neg, in_b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    // Sign fix-up
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        in_signed = ~op[0];
        in_a_neg  = in_signed & a[WIDTH-1];
        in_b_neg  = in_signed & b[WIDTH-1];
        abs_a     = in_a_neg ? (~a + 1'b1) : a;
        abs_b     = in_b_neg ? (~b + 1'b1) : b;

        // Shift-add: add multiplicand to upper half when the current multiplier
        // bit is set, then shift the whole product right (carry lands at top).
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};

        // Restoring divide: shift next dividend bit into the partial remainder.
        // When it is >= divisor the true difference is < divisor, so the
        // low WIDTH bits of the subtraction are exact.
        div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, mcand_q});
        div_diff = div_sh[WIDTH-1:0] - mcand_q;
        div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge};

        prod_neg = ~prod_q + 1'b1;
        // Overflow case (most-negative / -1) falls out naturally: the magnitude
        // quotient is 2^(WIDTH-1), both signs negative, so no negation is applied.
        quo = (a_neg_q ^ b_neg_q) ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
        rem = a_neg_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
                    cnt_d   = '0;
                    if (op[1] && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        if (op[1]) begin
                            prod_d  = {{WIDTH{1'b0}}, abs_a};
                            mcand_d = abs_b;
                        end else begin
                            prod_d  = {{WIDTH{1'b0}}, abs_b};
                            mcand_d = abs_a;
                        end
                        state_d = RUN;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                prod_d = op_q[1] ? div_next : mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (op_q[1]) begin
                    lo_d = quo;
                    hi_d = rem;
                end else if (a_neg_q ^ b_neg_q) begin
                    hi_d = prod_neg[2*WIDTH-1:WIDTH];
                    lo_d = prod_neg[WIDTH-1:0];
                end else begin
                    hi_d = prod_q[2*WIDTH-1:WIDTH];
                    lo_d = prod_q[WIDTH-1:0];
                end
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit (WIDTH=32).
// Stimulus pushes the hand-computed result of each operation into a queue.
// A negedge monitor pops and compares whenever done is seen.
// Latency is counted inclusively from the sampling edge to the edge entering DONE.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
                check({mon_e.name, "_dbz"}, W'(div_by_zero), W'(mon_e.dbz));
            end
        end
    end

    // Issue one operation (called #1 after a rising edge, unit idle).
    // disturb: pulse start + lo_we during RUN. wr_too: assert hi_we/lo_we with start.
    task automatic issue(input string name, input logic [1:0] o,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input bit disturb, input bit wr_too);
        int n;
        int exp_lat;
        logic [W-1:0] hi_before, lo_before;
        exp_lat   = ed ? 1 : int'(W) + 2;
        hi_before = hi;
        lo_before = lo;
        sb.push_back('{eh, el, ed, name});
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        if (wr_too) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'hBAD0_BAD0;
        end
        @(posedge clock); #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = ~av;   // operands must already be captured
        b     = ~bv;
        n     = 1;
        if (wr_too && !ed) check({name, "_wr_dropped"}, hi, hi_before);
        while (done !== 1'b1 && n < 200) begin
            if (disturb && n == 5) begin
                start = 1'b1;
                op    = ~o;
                lo_we = 1'b1;
                wdata = 32'h0000_DEAD;
            end
            @(posedge clock); #1;
            start = 1'b0;
            lo_we = 1'b0;
            n++;
            if (disturb && n == 6) begin
                check({name, "_busy_lo_hold"}, lo, lo_before);
                check({name, "_busy_during_run"}, W'(busy), W'(1));
            end
        end
        check({name, "_latency"}, W'(n), W'(exp_lat));
        @(posedge clock); #1;
        check({name, "_idle_busy"}, W'(busy), W'(0));
        check({name, "_idle_done"}, W'(done), W'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #1 reset = 1'b1;
        #2;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_dbz", W'(div_by_zero), W'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        // First start on the first edge after reset release
        issue("mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        issue("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
        issue("div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        issue("divu_by0",    OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0, 0);
        issue("divu_100d7",  OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 0, 0);
        issue("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 0);
        issue("mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0);
        issue("div_7dm2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0, 0);
        issue("div_m7dm2",   OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 0, 0);
        issue("div_m5by0",   OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0, 0);

        // Second start and lo_we during RUN are ignored
        issue("multu_6x7_dist", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1, 0);

        // MTLO / MTHI in IDLE
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clock); #1;
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h0000_1234);
        check("mtlo_hi_hold", hi, 32'h0000_0000);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(posedge clock); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthilo_hi", hi, 32'hCAFE_F00D);
        check("mthilo_lo", lo, 32'hCAFE_F00D);

        // start wins over a simultaneous write
        issue("multu_3x3_wr", OP_MULTU, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 0, 1);

        // Reset mid-operation: make hi/lo nonzero first, then abort a MULT
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555_AAAA;
        @(posedge clock); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd5;
        b     = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        issue("mult_5x5", OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, 0, 0);

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", W'(sb.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; hi, lo and wdata are WIDTH bits and the iteration count equals WIDTH.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on a rising edge.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: a is the multiplicand or dividend; b is the multiplier or divisor.
REQ-007 The block SHALL have ports hi_we and lo_we, input, 1 bit each, and wdata, input, WIDTH bits: MTHI/MTLO write path.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH bits each: the architectural HI/LO registers.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: set on completion of a DIV/DIVU with b == 0.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, FIX, DONE.
REQ-013 In IDLE, start=1 SHALL capture op, a and b, and move the FSM to RUN with the iteration counter at 0; if op is DIV/DIVU and b == 0, the FSM SHALL move to DONE instead.
REQ-014 RUN SHALL take exactly WIDTH cycles, one iteration per cycle: shift-add on operand magnitudes for multiply, restoring shift-subtract on magnitudes for divide; RUN SHALL then move to FIX.
REQ-015 FIX SHALL last one cycle and apply sign correction for signed ops, then move to DONE.
REQ-016 Signed multiply SHALL negate the 2*WIDTH product when sign(a) XOR sign(b) = 1.
REQ-017 Signed divide SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-018 On entry to DONE, the multiply result SHALL be written as hi = product[2W-1:W] and lo = product[W-1:0].
REQ-019 On entry to DONE, the divide result SHALL be written as lo = quotient and hi = remainder.
REQ-020 Divide by zero SHALL write hi = a, lo = all ones and div_by_zero = 1; every other completion SHALL clear div_by_zero.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000, hi = 0, with no flag.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 busy SHALL be high in RUN, FIX and DONE, and low only in IDLE.
REQ-024 Latency SHALL be WIDTH+2 edges from the sampling edge to the edge entering DONE (34 for WIDTH=32), or 1 edge for divide by zero.
REQ-025 start SHALL be ignored while busy = 1; there SHALL be no queuing.
REQ-026 In IDLE, hi_we and lo_we SHALL load wdata into hi and lo respectively on the clock edge; both may be asserted in the same cycle.
REQ-027 While busy = 1, hi_we and lo_we SHALL be ignored.
REQ-028 If start and hi_we or lo_we are both asserted in IDLE, start SHALL win and the write SHALL be dropped.
REQ-029 hi and lo SHALL hold their values between updates and SHALL change only on DONE entry or an accepted write.
REQ-030 Captured operands SHALL be internal copies; changes on a and b after the sampling edge SHALL not affect the result.

Reset
REQ-031 reset=1 SHALL asynchronously force the FSM to IDLE, the counter to 0, busy=0, done=0, hi=0, lo=0 and div_by_zero=0.
REQ-032 reset asserted mid-operation SHALL abort the operation and leave no partial result in hi or lo.
REQ-033 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 MULT a=0xFFFFFFFD (-3), b=7 -> done 34 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
REQ-037 DIVU a=100, b=0 -> done on the next cycle; hi=0x64, lo=0xFFFFFFFF, div_by_zero=1; then DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
REQ-038 A second start plus lo_we pulsed during RUN -> both ignored; the first result is intact, and lo_we with wdata=0x1234 in IDLE then sets lo=0x1234.
REQ-039 reset asserted 10 cycles into MULT 5*5 -> busy=0, hi=lo=0 immediately; a new MULT 5*5 then yields lo=25.
